// File: rtl/gpr_wr_arbiter_pkg.sv
// Shared register-file types: address width, data word, write-port FSM states
// and the per-requester write bundle.
package rfPhoenixPkg;
  localparam int NTHREADS = 4;
  localparam int NREGS    = 64;
  localparam int TidMSB   = $clog2(NTHREADS) - 1;
  localparam int GprAddrW = 7 + TidMSB;

  typedef logic [31:0] Value;

  typedef enum logic {CLEAR, RUN} gpr_wr_state_t;

  typedef struct packed {
    logic [3:0]          wr;
    logic [GprAddrW-1:0] wa;
    Value                dat;
  } gpr_wreq_t;
endpackage

// File: rtl/gpr_wr_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester above 'last',
// wrapping around; no grant when nothing requests.
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         grant
);
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    // Priority distance i from the previous winner; nearest requester wins.
    for (int i = 1; i <= NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == (int'(last) + i) % NREQ)) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/gpr_wr_arbiter.sv
// Register-file write-port controller: round-robin among writeback requesters.
// Define GPR_CLEAR_EN to zero every register word after reset before RUN.
module gpr_wr_arbiter
  import rfPhoenixPkg::*;
#(
  parameter int NREQ   = 3,
  parameter int NWORDS = NTHREADS * NREGS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_vld,
  input  logic [NREQ-1:0][3:0]           req_wr,
  input  logic [NREQ-1:0][GprAddrW-1:0]  req_wa,
  input  Value [NREQ-1:0]                req_dat,
  output logic [NREQ-1:0]                req_ack,
  output logic [3:0]                     rf_wr,
  output logic [GprAddrW-1:0]            rf_wa,
  output Value                           rf_dat,
  output logic                           busy
);
  localparam int LW = $clog2(NREQ);

  logic [LW-1:0]   last;
  logic [LW-1:0]   gnt_idx;
  logic [NREQ-1:0] grant;
  gpr_wreq_t       win;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req_vld),
    .last  (last),
    .grant (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) gnt_idx = LW'(j);
    end
    win = '{wr: req_wr[gnt_idx], wa: req_wa[gnt_idx], dat: req_dat[gnt_idx]};
  end

`ifdef GPR_CLEAR_EN
  localparam logic [GprAddrW-1:0] LAST_ADR = GprAddrW'(NWORDS - 1);

  gpr_wr_state_t       state;
  logic [GprAddrW-1:0] clr_adr;

  assign busy = (state == CLEAR);
`else
  logic unused_nwords;

  assign unused_nwords = NWORDS[0];
  assign busy          = 1'b0;
`endif

  // A request presented while in reset is dropped and must be re-presented.
  assign req_ack = (rst || busy) ? '0 : grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr  <= '0;
      rf_wa  <= '0;
      rf_dat <= '0;
      last   <= LW'(NREQ - 1);
`ifdef GPR_CLEAR_EN
      state   <= CLEAR;
      clr_adr <= '0;
`endif
    end
`ifdef GPR_CLEAR_EN
    else if (state == CLEAR) begin
      rf_wr  <= 4'hF;
      rf_wa  <= clr_adr;
      rf_dat <= '0;
      if (clr_adr == LAST_ADR) begin
        state   <= RUN;
        clr_adr <= '0;
      end else begin
        clr_adr <= clr_adr + 1'b1;
      end
    end
`endif
    else if (|grant) begin
      rf_wr  <= win.wr;
      rf_wa  <= win.wa;
      rf_dat <= win.dat;
      last   <= gnt_idx;
    end else begin
      rf_wr <= '0;
    end
  end
endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Bench for gpr_wr_arbiter: cycle model compared every cycle plus directed
// literal checks; follows GPR_CLEAR_EN the same way the design does.
module tb_gpr_wr_arbiter;
  import rfPhoenixPkg::*;

  localparam int NREQ = 3;
  localparam int NW   = NTHREADS * NREGS;
  localparam int IW   = $clog2(NREQ);
`ifdef GPR_CLEAR_EN
  localparam int CLR = NW;
`else
  localparam int CLR = 0;
`endif

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NREQ-1:0]               req_vld;
  logic [NREQ-1:0][3:0]          req_wr;
  logic [NREQ-1:0][GprAddrW-1:0] req_wa;
  Value [NREQ-1:0]               req_dat;
  logic [NREQ-1:0]               req_ack;
  logic [3:0]                    rf_wr;
  logic [GprAddrW-1:0]           rf_wa;
  Value                          rf_dat;
  logic                          busy;

  gpr_wr_arbiter #(.NREQ(NREQ), .NWORDS(NW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_wr  (req_wr),
    .req_wa  (req_wa),
    .req_dat (req_dat),
    .req_ack (req_ack),
    .rf_wr   (rf_wr),
    .rf_wa   (rf_wa),
    .rf_dat  (rf_dat),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remaining clear words, previous winner, expected port.
  bit                  m_valid = 1'b0;
  int                  m_clr_left;
  int                  m_last;
  logic [3:0]          m_wr;
  logic [GprAddrW-1:0] m_wa;
  Value                m_dat;

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] s;
    for (int n = 1; n <= NREQ; n++) begin
      s = v >> ((last + n) % NREQ);
      if (s[0]) return (last + n) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int k;
    if (rst) begin
      m_valid    = 1'b1;
      m_clr_left = CLR;
      m_last     = NREQ - 1;
      m_wr       = '0;
      m_wa       = '0;
      m_dat      = '0;
    end else if (m_valid) begin
      if (m_clr_left > 0) begin
        m_wr  = 4'hF;
        m_wa  = GprAddrW'(NW - m_clr_left);
        m_dat = '0;
        m_clr_left--;
      end else begin
        k = pick(req_vld, m_last);
        if (k < 0) begin
          m_wr = '0;
        end else begin
          m_wr   = req_wr[k[IW-1:0]];
          m_wa   = req_wa[k[IW-1:0]];
          m_dat  = req_dat[k[IW-1:0]];
          m_last = k;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int k;
    logic [NREQ-1:0] ea;
    if (m_valid) begin
      ea = '0;
      if (!rst && m_clr_left == 0) begin
        k = pick(req_vld, m_last);
        if (k >= 0) ea = NREQ'(1) << k;
      end
      chk("m_busy", busy, (m_clr_left > 0) ? 1 : 0);
      chk("m_ack", req_ack, ea);
      chk("m_rf_wr", rf_wr, m_wr);
      chk("m_rf_wa", rf_wa, m_wa);
      chk("m_rf_dat", rf_dat, m_dat);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] wr, input logic [GprAddrW-1:0] wa,
                         input Value dat);
    req_wr[k[IW-1:0]]  = wr;
    req_wa[k[IW-1:0]]  = wa;
    req_dat[k[IW-1:0]] = dat;
    req_vld[k[IW-1:0]] = 1'b1;
  endtask

  int order[$];
  int first_ack;

  // Hold requests until acked, dropping each one the cycle after its ack.
  task automatic drain(input int maxc);
    logic [NREQ-1:0] a;
    int c;
    order     = {};
    first_ack = -1;
    c         = 0;
    while (req_vld != '0 && c < maxc) begin
      #1 a = req_ack;
      if (a != '0) begin
        if (first_ack < 0) first_ack = c;
        order.push_back($clog2(a));
      end
      @(posedge clk);
      #1;
      req_vld = req_vld & ~a;
      c++;
    end
    chk("drain_done", req_vld, 0);
  endtask

  logic [NREQ-1:0] rec     [6];
  logic [NREQ-1:0] exp_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    rst = 1'b1; req_vld = '0; req_wr = '0; req_wa = '0; req_dat = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_wa", rf_wa, 0);
    chk("rst_busy", busy, (CLR > 0) ? 1 : 0);

    // Request held from reset release: acked in the first RUN cycle.
    set_req(0, 4'hF, 8'h11, 32'hA5A5_0000);
    drain(CLR + 8);
    chk("clr_req_ack_cycle", first_ack, CLR);
    chk("clr_req_wa", rf_wa, 8'h11);
    chk("clr_req_dat", rf_dat, 32'hA5A5_0000);
    chk("clr_req_wr", rf_wr, 4'hF);

    set_req(1, 4'hF, 8'h25, 32'hDEAD_BEEF);
    #1 chk("single_ack", req_ack, 3'b010);
    drain(4);
    chk("single_wa", rf_wa, 8'h25);
    chk("single_dat", rf_dat, 32'hDEAD_BEEF);
    chk("single_wr", rf_wr, 4'hF);
    cyc(1);
    chk("idle_wr", rf_wr, 0);
    chk("idle_wa_hold", rf_wa, 8'h25);

    set_req(2, 4'b0011, 8'h30, 32'h1234_5678);
    drain(4);
    chk("partial_wr", rf_wr, 4'b0011);
    chk("partial_dat", rf_dat, 32'h1234_5678);
    set_req(2, 4'h0, 8'h31, 32'h0);
    #1 chk("nowr_ack", req_ack, 3'b100);
    drain(4);
    chk("nowr_wr", rf_wr, 0);

    set_req(0, 4'hF, 8'h50, 32'h0000_0111);
    set_req(1, 4'hF, 8'h50, 32'h0000_0222);
    drain(6);
    chk("same_cnt", order.size(), 2);
    if (order.size() == 2) begin
      chk("same_first", order[0], 0);
      chk("same_second", order[1], 1);
    end
    chk("same_wa", rf_wa, 8'h50);
    chk("same_dat_last_wins", rf_dat, 32'h0000_0222);

    for (int k = 0; k < NREQ; k++) set_req(k, 4'hF, GprAddrW'(8'h60 + k), 32'hC0DE_0000 + k);
    drain(8);
    chk("rot_cnt", order.size(), 3);
    if (order.size() == 3) begin
      chk("rot_0", order[0], 2);
      chk("rot_1", order[1], 0);
      chk("rot_2", order[2], 1);
    end

    // Second reset: all three request continuously from reset release.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) set_req(k, 4'hF, GprAddrW'(8'h40 + k), 32'h1000_0000 * (k + 1));
`ifdef GPR_CLEAR_EN
    #1 chk("clr_c0_ack", req_ack, 0);
    cyc(1);
    chk("clr_c1_wr", rf_wr, 4'hF);
    chk("clr_c1_wa", rf_wa, 0);
    chk("clr_c1_busy", busy, 1);
    cyc(99);
    chk("clr_c100_wa", rf_wa, 99);
    rst = 1'b1;
    cyc(1);
    chk("midrst_wr", rf_wr, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_wa", rf_wa, 0);
    rst = 1'b0;
    cyc(1);
    chk("reclr_c1_wa", rf_wa, 0);
    chk("reclr_c1_wr", rf_wr, 4'hF);
    cyc(255);
    chk("reclr_end_busy", busy, 0);
    chk("reclr_end_wa", rf_wa, 8'hFF);
    chk("reclr_end_wr", rf_wr, 4'hF);
`endif
    for (int i = 0; i < 6; i++) begin
      #1 rec[i] = req_ack;
      cyc(1);
      chk("b2b_wr", rf_wr, 4'hF);
    end
    for (int i = 0; i < 6; i++) chk("b2b_ack_seq", rec[i], exp_seq[i]);
    req_vld = '0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
